// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: sequences a single-step shift_reg into a multi-position shifter
module shift_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_dir,
    input  logic [AW-1:0]    cmd_amt,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy,
    output logic             sr_load,
    output logic             sr_left_right,
    output logic [WIDTH-1:0] sr_data_in,
    input  logic [WIDTH-1:0] sr_data_out
);
    localparam logic [AW-1:0] MAX_AMT = AW'(WIDTH);
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_data;
    logic [AW-1:0]    r_steps;
    logic             r_dir, r_first, r_zero;
    logic             r_cmd_ready, r_rsp_valid, r_busy, r_load;
    always_comb begin
        w_next = (r_state == IDLE)  ? (cmd_valid ? ((cmd_amt == '0) ? DONE : SHIFT) : IDLE) :
                 (r_state == SHIFT) ? ((r_steps == AW'(1)) ? DONE : SHIFT) :
                 (r_state == DONE)  ? (rsp_ready ? IDLE : DONE) : IDLE;
    end
    // Handshake and load flags are registered from the next state so they never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_data      <= '0;
            r_dir       <= 1'b0;
            r_steps     <= '0;
            r_first     <= 1'b0;
            r_zero      <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_load      <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_cmd_ready <= (w_next == IDLE);
            r_busy      <= (w_next != IDLE);
            r_rsp_valid <= (w_next == DONE);
            r_load      <= (w_next == SHIFT);
            if (r_state == IDLE && cmd_valid) begin
                r_data  <= cmd_data;
                r_dir   <= cmd_dir;
                r_steps <= (cmd_amt > MAX_AMT) ? MAX_AMT : cmd_amt;
                r_first <= 1'b1;
                r_zero  <= (cmd_amt == '0);
            end
            if (r_state == SHIFT) begin
                r_first <= 1'b0;
                r_steps <= r_steps - AW'(1);
            end
        end
    end
    assign cmd_ready     = r_cmd_ready;
    assign rsp_valid     = r_rsp_valid;
    assign busy          = r_busy;
    assign sr_load       = r_load;
    assign sr_left_right = r_dir;
    assign sr_data_in    = (r_load && !r_first) ? sr_data_out : r_data;
    assign rsp_data      = r_zero ? r_data : sr_data_out;
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl: directed checks plus a cycle-by-cycle reference model of the shifter
module tb_shift_seq_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0, cmd_ready, cmd_dir = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic [3:0] cmd_amt = 4'd0;
    logic       rsp_valid, rsp_ready = 1'b1, busy;
    logic [7:0] rsp_data;
    logic       sr_load, sr_left_right;
    logic [7:0] sr_data_in, sr_data_out;
    int         n_cmp = 0, n_bad = 0;

    shift_seq_ctrl #(.WIDTH(8), .AW(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .cmd_dir(cmd_dir), .cmd_amt(cmd_amt),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .busy(busy), .sr_load(sr_load), .sr_left_right(sr_left_right),
        .sr_data_in(sr_data_in), .sr_data_out(sr_data_out)
    );

    always #5 clk = ~clk;

    // The attached single-step shift_reg with its synchronous reset.
    always @(posedge clk) begin
        if (!rst_n) sr_data_out <= 8'h00;
        else if (sr_load) sr_data_out <= sr_left_right ? (sr_data_in << 1) : (sr_data_in >> 1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: k counts cycles since acceptance (cycle 1 follows the accept edge).
    bit         m_busy = 1'b0;
    int         m_k, m_n;
    logic [7:0] m_res, m_op;
    logic       m_dir;
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_load", sr_load, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_busy", busy, 0);
            m_busy = 1'b0;
        end else begin
            chk("m_cmd_ready", cmd_ready, !m_busy);
            chk("m_busy", busy, m_busy);
            chk("m_load", sr_load, m_busy && m_k <= m_n);
            chk("m_rsp_valid", rsp_valid, m_busy && m_k > m_n);
            if (m_busy && m_k <= m_n) chk("m_dir", sr_left_right, m_dir);
            if (m_busy && m_k == 1 && m_n > 0) chk("m_first_in", sr_data_in, m_op);
            if (m_busy && m_k > m_n) chk("m_rsp_data", rsp_data, m_res);
            if (!m_busy && cmd_valid) begin
                m_busy = 1'b1;
                m_k    = 1;
                m_n    = (cmd_amt > 8) ? 8 : int'(cmd_amt);
                m_op   = cmd_data;
                m_dir  = cmd_dir;
                m_res  = (m_n >= 8) ? 8'h00 : cmd_dir ? 8'(cmd_data << m_n) : 8'(cmd_data >> m_n);
            end else if (m_busy) begin
                if (m_k > m_n && rsp_ready) m_busy = 1'b0;
                else m_k++;
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic dir, input logic [3:0] amt);
        int w = 0;
        cmd_valid = 1'b1; cmd_data = d; cmd_dir = dir; cmd_amt = amt;
        while (!cmd_ready && w < 20) begin
            @(posedge clk); #1; w++;
        end
        if (!cmd_ready) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    // Called in cycle 1; waits for the response and checks latency, load count and data.
    task automatic finish(input logic [7:0] exp, input int lat, input int loads, input int hold);
        int l = 1, nl = 0;
        logic [7:0] held;
        rsp_ready = (hold == 0);
        while (!rsp_valid && l < 40) begin
            nl += int'(sr_load);
            @(posedge clk); #1; l++;
        end
        chk("latency", l, lat);
        chk("load_count", nl, loads);
        chk("rsp_data", rsp_data, exp);
        held = rsp_data;
        for (int i = 0; i < hold; i++) begin
            if (i == 1) begin
                cmd_valid = 1'b1; cmd_data = 8'h3C; cmd_dir = 1'b1; cmd_amt = 4'd1;
            end
            @(posedge clk); #1;
            chk("bp_hold_data", rsp_data, held);
            chk("bp_hold_valid", rsp_valid, 1);
            chk("bp_cmd_ready", cmd_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_rsp_valid", rsp_valid, 0);
        chk("post_cmd_ready", cmd_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset_cmd_ready", cmd_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_lr", sr_left_right, 0);
        chk("reset_data_in", sr_data_in, 0);
        send(8'h81, 1'b1, 4'd3);  finish(8'h08, 4, 3, 0);
        send(8'hF0, 1'b0, 4'd2);  finish(8'h3C, 3, 2, 0);
        chk("busy_after_rsp", busy, 0);
        send(8'hA5, 1'b0, 4'd0);  finish(8'hA5, 1, 0, 0);
        send(8'hFF, 1'b1, 4'd12); finish(8'h00, 9, 8, 0);
        send(8'h5A, 1'b0, 4'd1);  finish(8'h2D, 2, 1, 5);
        chk("b2b_pending_valid", cmd_valid, 1);
        send(8'h3C, 1'b1, 4'd1);  finish(8'h78, 2, 1, 0);
        send(8'hC3, 1'b1, 4'd5);
        @(posedge clk); #1;
        chk("pre_rst_load", sr_load, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_load", sr_load, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("no_dropped_rsp", rsp_valid, 0);
        end
        send(8'h0F, 1'b1, 4'd4);  finish(8'hF0, 5, 4, 0);
        send(8'h96, 1'b0, 4'd8);  finish(8'h00, 9, 8, 0);
        send(8'h96, 1'b0, 4'd7);  finish(8'h01, 8, 7, 0);
        repeat (2) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
